count_updn_mod: RTL and testbench

- Parametrised successor to the team's fixed 4-bit up-counter.
- Generalises width and modulus; adds up/down direction, parallel load, count enable, a step prescaler, and a selectable wrap or saturate mode.
- Provides a terminal-count pulse and a sticky overflow flag.
- Used as the general-purpose event/timer counter in the training designs: display scanning, debounce timing, sequence indexing.

---
 rtl/count_updn_mod.sv | 73 +++++++
 tb/tb_count_updn_mod.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_updn_mod.sv
// Parametrised up/down counter with modulus, step prescaler, wrap/saturate boundary handling,
// a terminal-count pulse and a sticky overflow flag.
module count_updn_mod #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    localparam int               PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH:0]   MODW  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_val;
    logic             step;
    logic             boundary;

    // Next-value logic stays inside 0..MODULUS-1, so an out-of-range value is never registered.
    always_comb begin
        load_clamped = ({1'b0, load_val} >= MODW) ? MAXV : load_val;
        step         = en && (pre == PLAST);
        boundary     = up ? (out == MAXV) : (out == '0);
        step_val     = out;
        if (up) begin
            if (!boundary)
                step_val = out + WIDTH'(1);
            else if (SATURATE == 0)
                step_val = '0;
        end else begin
            if (!boundary)
                step_val = out - WIDTH'(1);
            else if (SATURATE == 0)
                step_val = MAXV;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
            pre <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (load) begin
            out <= load_clamped;
            pre <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (step) begin
            out <= step_val;
            pre <= '0;
            tc  <= boundary;
            ovf <= ovf | boundary;
        end else begin
            if (en)
                pre <= pre + PW'(1);
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_count_updn_mod.sv
// Self-checking bench: five counter configurations share one stimulus stream and are checked
// against a behavioural model every cycle, plus directed sequences for the corner cases.
module tb_count_updn_mod;

    localparam int NDUT = 5;

    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [7:0] load_val;

    logic [7:0] out_a;
    logic [3:0] out_b, out_c, out_d;
    logic [2:0] out_e;
    logic       tc_a, tc_b, tc_c, tc_d, tc_e;
    logic       ovf_a, ovf_b, ovf_c, ovf_d, ovf_e;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state, one slot per configuration.
    int m_w[NDUT]   = '{8, 4, 4, 4, 3};
    int m_mod[NDUT] = '{256, 10, 10, 16, 5};
    int m_sat[NDUT] = '{0, 0, 1, 0, 1};
    int m_ps[NDUT]  = '{1, 1, 1, 4, 3};
    int m_out[NDUT];
    int m_cnt[NDUT];
    int m_tc[NDUT];
    int m_ovf[NDUT];

    typedef struct {
        logic r, e, u, l;
        int   lv;
        int   eout, etc, eovf;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    count_updn_mod #(.WIDTH(8), .MODULUS(256), .SATURATE(0), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .out(out_a), .tc(tc_a), .ovf(ovf_a));
    count_updn_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val[3:0]), .out(out_b), .tc(tc_b), .ovf(ovf_b));
    count_updn_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) dut_c (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val[3:0]), .out(out_c), .tc(tc_c), .ovf(ovf_c));
    count_updn_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(4)) dut_d (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val[3:0]), .out(out_d), .tc(tc_d), .ovf(ovf_d));
    count_updn_mod #(.WIDTH(3), .MODULUS(5), .SATURATE(1), .PRESCALE(3)) dut_e (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val[2:0]), .out(out_e), .tc(tc_e), .ovf(ovf_e));

    function automatic int getOut(int k);
        case (k)
            0: return int'(out_a);
            1: return int'(out_b);
            2: return int'(out_c);
            3: return int'(out_d);
            default: return int'(out_e);
        endcase
    endfunction

    function automatic int getTc(int k);
        case (k)
            0: return int'(tc_a);
            1: return int'(tc_b);
            2: return int'(tc_c);
            3: return int'(tc_d);
            default: return int'(tc_e);
        endcase
    endfunction

    function automatic int getOvf(int k);
        case (k)
            0: return int'(ovf_a);
            1: return int'(ovf_b);
            2: return int'(ovf_c);
            3: return int'(ovf_d);
            default: return int'(ovf_e);
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Model works in terms of counting enabled cycles and applying the boundary rules directly.
    task automatic updateModel();
        for (int k = 0; k < NDUT; k++) begin
            int lv;
            lv = int'(load_val) % (1 << m_w[k]);
            if (reset) begin
                m_out[k] = 0; m_cnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
            end else if (load) begin
                m_out[k] = (lv >= m_mod[k]) ? m_mod[k] - 1 : lv;
                m_cnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
            end else if (en) begin
                m_cnt[k] = m_cnt[k] + 1;
                m_tc[k] = 0;
                if (m_cnt[k] == m_ps[k]) begin
                    bit hit;
                    m_cnt[k] = 0;
                    hit = up ? (m_out[k] == m_mod[k] - 1) : (m_out[k] == 0);
                    if (hit) begin
                        m_tc[k] = 1;
                        m_ovf[k] = 1;
                    end
                    if (!(hit && m_sat[k] != 0))
                        m_out[k] = (m_out[k] + (up ? 1 : -1) + m_mod[k]) % m_mod[k];
                end
            end else begin
                m_tc[k] = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic l, input int lv);
        reset = r; en = e; up = u; load = l; load_val = 8'(lv);
        @(posedge clk);
        #1;
        updateModel();
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("model dut%0d out", k), getOut(k), m_out[k]);
            checkOutput($sformatf("model dut%0d tc", k), getTc(k), m_tc[k]);
            checkOutput($sformatf("model dut%0d ovf", k), getOvf(k), m_ovf[k]);
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 3,  3, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  2, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  1, 0, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  0, 0, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  9, 1, 1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  8, 0, 1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 12, 9, 0, 0};

        // Reset and a full default-width up count past the natural wrap.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("reset out", int'(out_a), 0);
        checkOutput("reset tc", int'(tc_a), 0);
        checkOutput("reset ovf", int'(ovf_a), 0);
        for (int i = 1; i <= 260; i++) begin
            applyStimulus(0, 1, 1, 0, 0);
            checkOutput($sformatf("wrap256 out c%0d", i), int'(out_a), i % 256);
            checkOutput($sformatf("wrap256 tc c%0d", i), int'(tc_a), (i == 256) ? 1 : 0);
            checkOutput($sformatf("wrap256 ovf c%0d", i), int'(ovf_a), (i >= 256) ? 1 : 0);
        end

        // Modulus-10 down count with wrap and clamped load.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].l, tbl[i].lv);
            checkOutput($sformatf("mod10 out v%0d", i), int'(out_b), tbl[i].eout);
            checkOutput($sformatf("mod10 tc v%0d", i), int'(tc_b), tbl[i].etc);
            checkOutput($sformatf("mod10 ovf v%0d", i), int'(ovf_b), tbl[i].eovf);
        end

        // Saturating counter held at the top, then released downward.
        applyStimulus(0, 0, 1, 1, 8);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("sat out 9", int'(out_c), 9);
        checkOutput("sat tc first", int'(tc_c), 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 1, 0, 0);
            checkOutput($sformatf("sat hold out %0d", i), int'(out_c), 9);
            checkOutput($sformatf("sat hold tc %0d", i), int'(tc_c), 1);
        end
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("sat down out 8", int'(out_c), 8);
        checkOutput("sat down tc 8", int'(tc_c), 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("sat down out 7", int'(out_c), 7);
        checkOutput("sat down tc 7", int'(tc_c), 0);
        checkOutput("sat ovf sticky", int'(ovf_c), 1);

        // Prescaler: step every 4th enabled cycle, pause with en low, restart on load.
        applyStimulus(0, 0, 1, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1, 1, 0, 0);
            checkOutput($sformatf("ps out c%0d", i), int'(out_d), (i == 4) ? 1 : 0);
        end
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 0, 0);
            checkOutput($sformatf("ps paused out %0d", i), int'(out_d), 1);
        end
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("ps resume out", int'(out_d), 1);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("ps delayed step", int'(out_d), 2);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 1, 5);
        checkOutput("ps load out", int'(out_d), 5);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1, 1, 0, 0);
            checkOutput($sformatf("ps reload c%0d", i), int'(out_d), (i == 4) ? 6 : 5);
        end

        // Simultaneous events: reset over load, load over a step.
        applyStimulus(1, 1, 1, 1, 9);
        checkOutput("reset beats load", int'(out_a), 0);
        applyStimulus(0, 0, 1, 1, 255);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("pre-load ovf set", int'(ovf_a), 1);
        applyStimulus(0, 1, 1, 1, 42);
        checkOutput("load beats step out", int'(out_a), 42);
        checkOutput("load beats step tc", int'(tc_a), 0);
        checkOutput("load clears ovf", int'(ovf_a), 0);

        // Reset mid-count and mid-prescale.
        applyStimulus(0, 0, 1, 1, 15);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 1, 0, 0);
        checkOutput("mid ovf set", int'(ovf_d), 1);
        for (int i = 0; i < 30; i++)
            applyStimulus(0, 1, 1, 0, 0);
        checkOutput("mid out 7", int'(out_d), 7);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("mid reset out", int'(out_d), 0);
        checkOutput("mid reset ovf", int'(ovf_d), 0);
        checkOutput("mid reset tc", int'(tc_d), 0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1, 1, 0, 0);
            checkOutput($sformatf("post-reset c%0d", i), int'(out_d), (i == 4) ? 1 : 0);
        end

        // Randomised traffic against the model on all configurations.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                          int'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
